// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op encodings, FSM states and default latencies for the mult/div unit
package md_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic op_is_div(logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// rtl/md_ctrl_if.sv - E/D-stage pipeline bundle between the datapath and the mult/div controller
interface md_ctrl_if;

  logic        start;
  logic        mt_we;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        kill;
  logic        md_use_d;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, mt_we, op, a, b, kill, md_use_d,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, mt_we, op, a, b, kill, md_use_d,
    output busy, stall_req, hi, lo
  );

endinterface

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational signed/unsigned multiply and divide producing HI/LO results
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o,
  output logic        div_zero_o
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] b_safe;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quo_u;
  logic        [31:0] rem_u;
  logic               div_ovf;

  always_comb begin
    prod_s     = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    prod_u     = {32'd0, a_i} * {32'd0, b_i};
    div_zero_o = op_is_div(op_i) && (b_i == 32'd0);
    div_ovf    = (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    // Dividing by 1 yields exactly the MIN/-1 answer (q=MIN, r=0) and keeps /0 defined.
    b_safe     = (b_i == 32'd0 || div_ovf) ? 32'd1 : b_i;
    quo_s      = $signed(a_i) / $signed(b_safe);
    rem_s      = $signed(a_i) % $signed(b_safe);
    quo_u      = a_i / b_safe;
    rem_u      = a_i % b_safe;

    res_hi_o = 32'd0;
    res_lo_o = 32'd0;
    case (op_i)
      OP_MULT:  {res_hi_o, res_lo_o} = prod_s;
      OP_MULTU: {res_hi_o, res_lo_o} = prod_u;
      OP_DIV: begin
        res_hi_o = rem_s;
        res_lo_o = quo_s;
      end
      OP_DIVU: begin
        res_hi_o = rem_u;
        res_lo_o = quo_u;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - HI/LO owner that sequences multi-cycle mult/div ops and requests D-stage stalls
module md_ctrl
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic      clk,
  input  logic      reset,
  md_ctrl_if.slave  md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_zero;

  md_arith u_arith (
    .op_i       (md.op),
    .a_i        (md.a),
    .b_i        (md.b),
    .res_hi_o   (res_hi),
    .res_lo_o   (res_lo),
    .div_zero_o (div_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (md.start && !md.kill) begin
          // HI/LO cannot change while busy, so a /0 simply re-commits the current values.
          pend_hi_d = div_zero ? hi_q : res_hi;
          pend_lo_d = div_zero ? lo_q : res_lo;
          cnt_d     = op_is_div(md.op) ? DIV_LOAD : MULT_LOAD;
          state_d   = ST_BUSY;
        end else if (md.mt_we && !md.kill) begin
          if (md.op == OP_MTHI) hi_d = md.a;
          else if (md.op == OP_MTLO) lo_d = md.a;
        end
      end
      ST_BUSY: begin
        if (md.kill) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    md.busy      = (state_q == ST_BUSY);
    md.stall_req = md.md_use_d & ((state_q == ST_BUSY) | md.start);
    md.hi        = hi_q;
    md.lo        = lo_q;
  end

endmodule

// File: tb/tb_md_ctrl.sv
// tb/tb_md_ctrl.sv - randomized self-checking bench for md_ctrl against a 64-bit arithmetic model
module tb_md_ctrl;
  import md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_ctrl_if bus ();

  md_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model_result(logic [2:0] op, logic [31:0] a, logic [31:0] b,
                                               logic [31:0] cur_hi, logic [31:0] cur_lo);
    longint sa, sb, q, r;
    longint unsigned ua, ub, uq, ur, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      OP_MULT: begin
        q = sa * sb;
        return q;
      end
      OP_MULTU: begin
        up = ua * ub;
        return up;
      end
      OP_DIV: begin
        if (b == 32'd0) return {cur_hi, cur_lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 32'd0) return {cur_hi, cur_lo};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
    endcase
  endfunction

  function automatic int op_cycles(logic [2:0] op);
    return (op == OP_DIV || op == OP_DIVU) ? DC : MC;
  endfunction

  task automatic test_reset();
    bus.start = 0; bus.mt_we = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    bus.kill = 0; bus.md_use_d = 1;
    reset = 0;
    step(); step();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.hi !== 32'd0) begin miscompares++; $display("FAIL rst_hi got=%h exp=0", bus.hi); end
    vectors++; if (bus.lo !== 32'd0) begin miscompares++; $display("FAIL rst_lo got=%h exp=0", bus.lo); end
    reset = 1;
    step();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rel_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.stall_req !== 1'b0) begin miscompares++; $display("FAIL rel_stall got=%b exp=0", bus.stall_req); end
    m_hi = 0; m_lo = 0;
  endtask

  task automatic test_ops();
    logic [2:0]  d_op [5] = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_DIV};
    logic [31:0] d_a  [5] = '{32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFF9, 32'd7, 32'h80000000};
    logic [31:0] d_b  [5] = '{32'd3, 32'd3, 32'd2, 32'd0, 32'hFFFFFFFF};
    logic [31:0] d_hi [5] = '{32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
    logic [31:0] d_lo [5] = '{32'hFFFFFFFA, 32'hFFFFFFFA, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000};
    logic [2:0] op; logic [31:0] a, b; logic use_d; logic [63:0] exp;
    int n, cnt, stalls;
    for (int i = 0; i < 30; i++) begin
      if (i < 5) begin
        op = d_op[i]; a = d_a[i]; b = d_b[i]; use_d = 1'b1;
      end else begin
        op = 3'($urandom_range(0, 3));
        a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
        case ($urandom_range(0, 7))
          0: b = 32'd0;
          1: b = 32'hFFFFFFFF;
          default: b = $urandom;
        endcase
        use_d = 1'($urandom_range(0, 1));
      end
      exp = model_result(op, a, b, m_hi, m_lo);
      n = op_cycles(op);
      bus.op = op; bus.a = a; bus.b = b; bus.md_use_d = use_d; bus.start = 1;
      #1;
      vectors++; if (bus.stall_req !== use_d) begin miscompares++; $display("FAIL issue_stall[%0d] got=%b exp=%b", i, bus.stall_req, use_d); end
      step();
      bus.start = 0;
      bus.a = $urandom; bus.b = $urandom;
      cnt = 0; stalls = 0;
      while (bus.busy === 1'b1 && cnt < 40) begin
        if (bus.stall_req === 1'b1) stalls++;
        step();
        cnt++;
      end
      vectors++; if (cnt !== n) begin miscompares++; $display("FAIL busy_len[%0d] op=%0d got=%0d exp=%0d", i, op, cnt, n); end
      vectors++; if (stalls !== (use_d ? n : 0)) begin miscompares++; $display("FAIL busy_stall[%0d] got=%0d exp=%0d", i, stalls, use_d ? n : 0); end
      vectors++; if ({bus.hi, bus.lo} !== exp) begin miscompares++; $display("FAIL result[%0d] op=%0d a=%h b=%h got=%h_%h exp=%h", i, op, a, b, bus.hi, bus.lo, exp); end
      if (i < 5) begin
        vectors++; if (bus.hi !== d_hi[i] || bus.lo !== d_lo[i]) begin miscompares++; $display("FAIL directed[%0d] got=%h_%h exp=%h_%h", i, bus.hi, bus.lo, d_hi[i], d_lo[i]); end
      end
      m_hi = exp[63:32]; m_lo = exp[31:0];
    end
  endtask

  task automatic test_kill();
    logic [2:0] op; int k, n;
    bus.md_use_d = 0;
    for (int i = 0; i < 5; i++) begin
      op = 3'($urandom_range(0, 3));
      n = op_cycles(op);
      k = (i == 0) ? 2 : (i == 1) ? n - 1 : $urandom_range(0, n - 1);
      bus.op = op; bus.a = $urandom; bus.b = $urandom | 32'd1; bus.start = 1;
      step();
      bus.start = 0;
      for (int j = 0; j < k; j++) step();
      vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL kill_pre_busy[%0d] got=%b exp=1", i, bus.busy); end
      bus.kill = 1;
      step();
      bus.kill = 0;
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL kill_busy[%0d] got=%b exp=0", i, bus.busy); end
      for (int j = 0; j < n + 2; j++) step();
      vectors++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin miscompares++; $display("FAIL kill_hold[%0d] got=%h_%h exp=%h_%h", i, bus.hi, bus.lo, m_hi, m_lo); end
    end
    bus.op = OP_MULT; bus.a = $urandom; bus.b = $urandom; bus.start = 1; bus.kill = 1;
    step();
    bus.start = 0; bus.kill = 0;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL start_kill_busy got=%b exp=0", bus.busy); end
    step();
    vectors++; if (bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo) begin miscompares++; $display("FAIL start_kill_hold busy=%b got=%h_%h exp=%h_%h", bus.busy, bus.hi, bus.lo, m_hi, m_lo); end
  endtask

  task automatic test_mt();
    logic [31:0] a; logic [2:0] op; logic kl; logic [63:0] exp; int cnt;
    bus.op = OP_MTLO; bus.a = 32'h1234; bus.mt_we = 1;
    step();
    bus.mt_we = 0;
    m_lo = 32'h1234;
    vectors++; if (bus.lo !== 32'h1234 || bus.hi !== m_hi || bus.busy !== 1'b0) begin miscompares++; $display("FAIL mtlo got=%h_%h busy=%b exp=%h_%h", bus.hi, bus.lo, bus.busy, m_hi, m_lo); end
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      op = $urandom_range(0, 1) ? OP_MTHI : OP_MTLO;
      kl = ($urandom_range(0, 3) == 0);
      bus.op = op; bus.a = a; bus.kill = kl; bus.mt_we = 1;
      step();
      bus.mt_we = 0; bus.kill = 0;
      if (!kl) begin
        if (op == OP_MTHI) m_hi = a; else m_lo = a;
      end
      vectors++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin miscompares++; $display("FAIL mt_rand[%0d] kill=%b got=%h_%h exp=%h_%h", i, kl, bus.hi, bus.lo, m_hi, m_lo); end
    end
    bus.op = OP_MULTU; bus.a = $urandom; bus.b = $urandom; bus.start = 1;
    exp = model_result(OP_MULTU, bus.a, bus.b, m_hi, m_lo);
    step();
    bus.start = 0;
    bus.op = OP_MTLO; bus.a = 32'hDEADBEEF; bus.mt_we = 1;
    step(); step();
    bus.mt_we = 0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin step(); cnt++; end
    vectors++; if ({bus.hi, bus.lo} !== exp) begin miscompares++; $display("FAIL mt_busy got=%h_%h exp=%h", bus.hi, bus.lo, exp); end
    m_hi = exp[63:32]; m_lo = exp[31:0];
  endtask

  task automatic test_reset_mid();
    logic [63:0] exp; int cnt;
    bus.op = OP_DIV; bus.a = $urandom; bus.b = $urandom | 32'd1; bus.start = 1;
    step();
    bus.start = 0;
    step(); step();
    #2 reset = 0;
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin miscompares++; $display("FAIL rstmid_hilo got=%h_%h exp=0_0", bus.hi, bus.lo); end
    m_hi = 0; m_lo = 0;
    step();
    reset = 1;
    step();
    bus.op = OP_MULT; bus.a = $urandom; bus.b = $urandom; bus.start = 1;
    exp = model_result(OP_MULT, bus.a, bus.b, m_hi, m_lo);
    step();
    bus.start = 0;
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 40) begin step(); cnt++; end
    vectors++; if (cnt !== MC || {bus.hi, bus.lo} !== exp) begin miscompares++; $display("FAIL rstmid_after len=%0d exp_len=%0d got=%h_%h exp=%h", cnt, MC, bus.hi, bus.lo, exp); end
    m_hi = exp[63:32]; m_lo = exp[31:0];
  endtask

  initial begin
    test_reset();
    test_ops();
    test_kill();
    test_mt();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
